// File: rtl/io_ctrl.sv
// LED/button I/O controller: synchronises and debounces buttons, latches sticky
// press events with an interrupt, and drives LEDs as off/on/blink/follow-button.
module io_ctrl #(
    parameter int NB                = 2,
    parameter int NL                = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BLINK_HALF_PERIOD = 1000000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NB-1:0]   button_i,
    output logic [NB-1:0]   button_o,
    output logic [NB-1:0]   press_pending_o,
    input  logic [NB-1:0]   event_clear_i,
    output logic            irq_o,
    input  logic [2*NL-1:0] led_mode_i,
    output logic [NL-1:0]   led_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        LED_OFF    = 2'b00,
        LED_ON     = 2'b01,
        LED_BLINK  = 2'b10,
        LED_FOLLOW = 2'b11
    } led_mode_e;

    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic [NB-1:0] button_q;
    logic [NB-1:0] button_d;
    logic [NB-1:0] pending_q;
    logic [NB-1:0] pending_d;
    logic          irq_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          phase_q;
    logic          phase_d;
    logic [NL-1:0] led_q;
    logic [NL-1:0] led_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
        end
    end

    // A level is accepted only after it has differed from the stable state for
    // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
    always_comb begin
        button_d = button_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != button_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    button_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        pending_d = (pending_q & ~event_clear_i) | (button_d & ~button_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            button_q  <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            button_q  <= button_d;
            pending_q <= pending_d;
            irq_q     <= |pending_q;
        end
    end

    always_comb begin
        pre_d   = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
        phase_d = phase_q ^ (pre_q == PRE_MAX);
    end

    // Follow mode wraps LED indices onto the available buttons.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NL; i++) begin
            case (led_mode_e'(led_mode_i[2*i +: 2]))
                LED_OFF:    led_d[i] = 1'b0;
                LED_ON:     led_d[i] = 1'b1;
                LED_BLINK:  led_d[i] = phase_q;
                LED_FOLLOW: led_d[i] = button_q[i % NB];
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign button_o        = button_q;
    assign press_pending_o = pending_q;
    assign irq_o           = irq_q;
    assign led_o           = led_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl with short debounce and blink periods.
module tb_io_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] buttonIn;
   logic [1:0] buttonOut;
   logic [1:0] pendingOut;
   logic [1:0] eventClear;
   logic       irqOut;
   logic [3:0] ledMode;
   logic [1:0] ledOut;
   logic [1:0] blinkTable [15];

   int checkCount = 0;
   int failCount  = 0;

   io_ctrl #(
      .NB(2),
      .NL(2),
      .DEBOUNCE_CYCLES(4),
      .BLINK_HALF_PERIOD(3)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .button_i(buttonIn),
      .button_o(buttonOut),
      .press_pending_o(pendingOut),
      .event_clear_i(eventClear),
      .irq_o(irqOut),
      .led_mode_i(ledMode),
      .led_o(ledOut)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive all functional inputs at once.
   task automatic applyStimulus(input logic [1:0] btn, input logic [1:0] clr, input logic [3:0] mode);
      buttonIn   = btn;
      eventClear = clr;
      ledMode    = mode;
   endtask

   // Single comparison point; counts and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence: reset, debounce, glitch, clear, follow, async reset, blink.
   initial begin
      rst = 1'b1;
      applyStimulus(2'b00, 2'b00, 4'b0000);
      waitCycles(2);
      checkOutput("reset_button", buttonOut, 2'b00);
      checkOutput("reset_pending", pendingOut, 2'b00);
      checkOutput("reset_irq", irqOut, 1'b0);
      checkOutput("reset_led", ledOut, 2'b00);
      rst = 1'b0;

      applyStimulus(2'b01, 2'b00, 4'b0000);
      waitCycles(5);
      checkOutput("t1_button_early", buttonOut, 2'b00);
      waitCycles(1);
      checkOutput("t1_button_rise", buttonOut, 2'b01);
      checkOutput("t1_pending_set", pendingOut, 2'b01);
      checkOutput("t1_irq_lag", irqOut, 1'b0);
      waitCycles(1);
      checkOutput("t1_irq_set", irqOut, 1'b1);

      applyStimulus(2'b11, 2'b00, 4'b0000);
      waitCycles(3);
      applyStimulus(2'b01, 2'b00, 4'b0000);
      waitCycles(8);
      checkOutput("t2_glitch_button", buttonOut, 2'b01);
      checkOutput("t2_glitch_pending", pendingOut, 2'b01);
      applyStimulus(2'b11, 2'b00, 4'b0000);
      waitCycles(5);
      checkOutput("t2_hold_early", buttonOut, 2'b01);
      waitCycles(1);
      checkOutput("t2_hold_button", buttonOut, 2'b11);
      checkOutput("t2_hold_pending", pendingOut, 2'b11);

      applyStimulus(2'b11, 2'b10, 4'b0000);
      waitCycles(1);
      checkOutput("t3_clear1_pending", pendingOut, 2'b01);
      applyStimulus(2'b11, 2'b01, 4'b0000);
      waitCycles(1);
      checkOutput("t3_clear0_pending", pendingOut, 2'b00);
      checkOutput("t3_irq_still", irqOut, 1'b1);
      applyStimulus(2'b11, 2'b00, 4'b0000);
      waitCycles(1);
      checkOutput("t3_irq_drop", irqOut, 1'b0);
      applyStimulus(2'b00, 2'b00, 4'b0000);
      waitCycles(7);
      checkOutput("t3_release_button", buttonOut, 2'b00);
      checkOutput("t3_release_pending", pendingOut, 2'b00);
      applyStimulus(2'b01, 2'b00, 4'b0000);
      waitCycles(5);
      applyStimulus(2'b01, 2'b01, 4'b0000);
      waitCycles(1);
      checkOutput("t3_setwins_button", buttonOut, 2'b01);
      checkOutput("t3_setwins_pending", pendingOut, 2'b01);
      applyStimulus(2'b01, 2'b00, 4'b0000);
      waitCycles(1);
      checkOutput("t3_setwins_hold", pendingOut, 2'b01);
      checkOutput("t3_setwins_irq", irqOut, 1'b1);

      applyStimulus(2'b01, 2'b00, 4'b1100);
      waitCycles(1);
      checkOutput("t5_follow_low", ledOut, 2'b00);
      applyStimulus(2'b11, 2'b00, 4'b1100);
      waitCycles(6);
      checkOutput("t5_button_rise", buttonOut, 2'b11);
      checkOutput("t5_follow_lag", ledOut, 2'b00);
      waitCycles(1);
      checkOutput("t5_follow_high", ledOut, 2'b10);

      applyStimulus(2'b00, 2'b00, 4'b1100);
      waitCycles(7);
      checkOutput("t6_pre_button", buttonOut, 2'b00);
      applyStimulus(2'b01, 2'b00, 4'b1100);
      waitCycles(4);
      checkOutput("t6_pre_pending", pendingOut, 2'b11);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_async_button", buttonOut, 2'b00);
      checkOutput("t6_async_pending", pendingOut, 2'b00);
      checkOutput("t6_async_irq", irqOut, 1'b0);
      checkOutput("t6_async_led", ledOut, 2'b00);
      waitCycles(1);
      rst = 1'b0;
      waitCycles(5);
      checkOutput("t6_requal_early", buttonOut, 2'b00);
      waitCycles(1);
      checkOutput("t6_requal_button", buttonOut, 2'b01);
      checkOutput("t6_requal_pending", pendingOut, 2'b01);

      blinkTable = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00,
                     2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
      waitCycles(1);
      rst = 1'b1;
      applyStimulus(2'b00, 2'b00, 4'b1010);
      waitCycles(1);
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (k == 9) applyStimulus(2'b00, 2'b00, 4'b1001);
         waitCycles(1);
         checkOutput($sformatf("t4_blink_%0d", k + 1), ledOut, blinkTable[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
